// File: rtl/des_pkg.sv
// des_pkg: DES tables, decrypt key-shift schedule and FSM state type.
// Permutation helpers use DES numbering: bit 1 is the MSB.
package des_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READY,
    ROUND,
    OUT
  } state_t;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41, 9, 49, 17, 57, 25
  };

  localparam int E_T [48] = '{
    32, 1, 2, 3, 4, 5,
    4, 5, 6, 7, 8, 9,
    8, 9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32, 1
  };

  localparam int P_T [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17,
    1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9,
    19, 13, 30, 6, 22, 11, 4, 25
  };

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17, 9,
    1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27,
    19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
    7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29,
    21, 13, 5, 28, 20, 12, 4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24, 1, 5,
    3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8,
    16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Index = {row(b1,b6), col(b2..b5)}.
  localparam logic [3:0] SBOX [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}
  };

  // Right-rotate applied to C/D before decrypt round n (1..16).
  // Walks the encrypt schedule backwards; C16 == C0.
  localparam logic [1:0] DEC_SHIFT [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [1:0] dec_shift(input int n);
    return DEC_SHIFT[n % 16];
  endfunction

  function automatic logic [63:0] ip_f(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] fp_f(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] e_f(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] p_f(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
    return y;
  endfunction

  function automatic logic [55:0] pc1_f(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] pc2_f(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] sbox_f(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0]  b;
    y = '0;
    for (int j = 0; j < 8; j++) begin
      b = x[47-6*j -: 6];
      y[31-4*j -: 4] = SBOX[j][{b[5], b[0], b[4:1]}];
    end
    return y;
  endfunction

endpackage

// File: rtl/des_round.sv
// des_round: one combinational DES decrypt round with on-the-fly subkey.
// Ports: l_i/r_i/c_i/d_i/shift_i in; l_o/r_o/c_o/d_o out.
module des_round
  import des_pkg::*;
(
  input  logic [31:0] l_i,
  input  logic [31:0] r_i,
  input  logic [27:0] c_i,
  input  logic [27:0] d_i,
  input  logic [1:0]  shift_i,
  output logic [31:0] l_o,
  output logic [31:0] r_o,
  output logic [27:0] c_o,
  output logic [27:0] d_o
);

  logic [47:0] subkey;
  logic [31:0] f_out;

  always_comb begin
    c_o = c_i;
    d_o = d_i;
    unique case (shift_i)
      2'd1: begin
        c_o = {c_i[0], c_i[27:1]};
        d_o = {d_i[0], d_i[27:1]};
      end
      2'd2: begin
        c_o = {c_i[1:0], c_i[27:2]};
        d_o = {d_i[1:0], d_i[27:2]};
      end
      default: ;
    endcase
  end

  assign subkey = pc2_f({c_o, d_o});
  assign f_out  = p_f(sbox_f(e_f(r_i) ^ subkey));
  assign l_o    = r_i;
  assign r_o    = l_i ^ f_out;

endmodule

// File: rtl/des_cbc_decrypt.sv
// des_cbc_decrypt: iterative DES decrypt with optional CBC chaining.
// Ports: clk, reset (sync, high), start/key/iv/cbc message setup,
// in_* ciphertext valid/ready, out_* plaintext valid/ready, busy.
// Macro DES_BLKCNT_EN adds blk_cnt[31:0] (delivered blocks since start).
module des_cbc_decrypt
  import des_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] key,
  input  logic [63:0] iv,
  input  logic        cbc,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
`ifdef DES_BLKCNT_EN
  ,
  output logic [31:0] blk_cnt
`endif
);

  localparam int RPC       = ROUNDS_PER_CYCLE;
  localparam int ROUND_CYC = 16 / RPC;

  state_t      state_q, state_d;
  logic [63:0] key_q, key_d;
  logic [63:0] chain_q, chain_d;
  logic        cbc_q, cbc_d;
  logic [63:0] ct_q, ct_d;
  logic [31:0] l_q, l_d;
  logic [31:0] r_q, r_d;
  logic [27:0] c_q, c_d;
  logic [27:0] d_q, d_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] out_q, out_d;
`ifdef DES_BLKCNT_EN
  logic [31:0] blk_q, blk_d;
`endif

  logic [31:0] l_w [RPC+1];
  logic [31:0] r_w [RPC+1];
  logic [27:0] c_w [RPC+1];
  logic [27:0] d_w [RPC+1];

  assign l_w[0] = l_q;
  assign r_w[0] = r_q;
  assign c_w[0] = c_q;
  assign d_w[0] = d_q;

  for (genvar k = 0; k < RPC; k++) begin : g_rnd
    des_round u_round (
      .l_i     (l_w[k]),
      .r_i     (r_w[k]),
      .c_i     (c_w[k]),
      .d_i     (d_w[k]),
      .shift_i (dec_shift(int'(cnt_q) * RPC + k)),
      .l_o     (l_w[k+1]),
      .r_o     (r_w[k+1]),
      .c_o     (c_w[k+1]),
      .d_o     (d_w[k+1])
    );
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    chain_d = chain_q;
    cbc_d   = cbc_q;
    ct_d    = ct_q;
    l_d     = l_q;
    r_d     = r_q;
    c_d     = c_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
`ifdef DES_BLKCNT_EN
    blk_d   = blk_q;
`endif
    if (start) begin
      state_d = READY;
      key_d   = key;
      chain_d = iv;
      cbc_d   = cbc;
      cnt_d   = '0;
`ifdef DES_BLKCNT_EN
      blk_d   = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: ;
        READY: begin
          if (in_valid) begin
            ct_d       = in_data;
            {l_d, r_d} = ip_f(in_data);
            {c_d, d_d} = pc1_f(key_q);
            cnt_d      = '0;
            state_d    = ROUND;
          end
        end
        ROUND: begin
          // Extra cycle after the last round registers the output.
          if (cnt_q == 5'(ROUND_CYC)) begin
            out_d = fp_f({r_q, l_q})
                  ^ (cbc_q ? chain_q : 64'h0);
            state_d = OUT;
          end else begin
            l_d   = l_w[RPC];
            r_d   = r_w[RPC];
            c_d   = c_w[RPC];
            d_d   = d_w[RPC];
            cnt_d = cnt_q + 5'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            chain_d = ct_q;
            state_d = READY;
`ifdef DES_BLKCNT_EN
            blk_d   = blk_q + 32'd1;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      chain_q <= '0;
      cbc_q   <= 1'b0;
      ct_q    <= '0;
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
`ifdef DES_BLKCNT_EN
      blk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      chain_q <= chain_d;
      cbc_q   <= cbc_d;
      ct_q    <= ct_d;
      l_q     <= l_d;
      r_q     <= r_d;
      c_q     <= c_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
`ifdef DES_BLKCNT_EN
      blk_q   <= blk_d;
`endif
    end
  end

  assign in_ready  = (state_q == READY);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q == ROUND) | (state_q == OUT);
  assign out_data  = out_q;
`ifdef DES_BLKCNT_EN
  assign blk_cnt   = blk_q;
`endif

endmodule
